decode: RTL and testbench

- Second stage of the pipelined MIPS core, directly downstream of fetch.
- Owns the IF/ID and ID/EX pipeline registers and the 32x32 register file.
- Extracts instruction fields and produces immediates, destination register and control flags.
- Detects load-use hazards and drives the stall that freezes fetch.

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/reg_file.sv | 35 +++
 rtl/decode.sv | 155 +++++++++++++++
 tb/tb_decode.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction fields
// and the IF/ID and ID/EX pipeline bundles.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] NOP_INSN = 32'h00000000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;
  } insn_fields_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        is_load;
  } id_ex_t;

  function automatic insn_fields_t fields(
    input logic [31:0] w
  );
    insn_fields_t r;
    r.opcode = w[31:26];
    r.rs     = w[25:21];
    r.rt     = w[20:16];
    r.rd     = w[15:11];
    r.shamt  = w[10:6];
    r.funct  = w[5:0];
    r.imm16  = w[15:0];
    r.target = w[25:0];
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two async read ports with
// same-cycle writeback bypass, r0 hardwired to zero.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode.sv
// Decode stage: IF/ID and ID/EX registers, field decode,
// register file reads and load-use hazard stall.
module decode
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h80020000,
  parameter logic [31:0] NOP_INSN = mips_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_out,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        is_load
);

  if_id_t       if_id;
  id_ex_t       id_ex;
  id_ex_t       dec;
  id_ex_t       ex_bubble;
  if_id_t       if_bubble;
  insn_fields_t f;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        is_r;
  logic        is_ai;
  logic        is_ld;
  logic        is_st;
  logic        is_br;
  logic        is_jal;
  logic        zext;
  logic        uses_rt;
  logic [4:0]  dest;
  logic        unused;

  assign f = fields(if_id.insn);
  assign unused = ^{f.shamt, f.target};

  reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (f.rs),
    .ra2 (f.rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  assign is_r   = f.opcode == OP_RTYPE;
  assign is_ai  = f.opcode inside
    {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  assign is_ld  = f.opcode inside
    {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_st  = f.opcode inside {OP_SB, OP_SH, OP_SW};
  assign is_br  = f.opcode inside {OP_BEQ, OP_BNE};
  assign is_jal = f.opcode == OP_JAL;
  assign zext   = f.opcode inside
    {OP_ANDI, OP_ORI, OP_XORI};

  // J and unknown opcodes fall to the default: no write
  always_comb begin
    dest    = 5'd0;
    uses_rt = 1'b0;
    unique case (1'b1)
      is_r: begin
        dest    = (f.funct == FUNCT_JR) ? 5'd0 : f.rd;
        uses_rt = 1'b1;
      end
      is_ai:  dest    = f.rt;
      is_ld:  dest    = f.rt;
      is_st:  uses_rt = 1'b1;
      is_br:  uses_rt = 1'b1;
      is_jal: dest    = 5'd31;
      default: ;
    endcase
  end

  always_comb begin
    dec.valid     = if_id.valid;
    dec.pc        = if_id.pc;
    dec.insn      = if_id.insn;
    dec.rs_data   = rs_val;
    dec.rt_data   = rt_val;
    dec.imm       = zext ? {16'h0, f.imm16}
                         : {{16{f.imm16[15]}}, f.imm16};
    dec.dest_reg  = dest;
    dec.reg_write = if_id.valid && dest != 5'd0;
    dec.is_load   = if_id.valid && is_ld;
  end

  always_comb begin
    ex_bubble          = '0;
    ex_bubble.pc       = if_id.pc;
    ex_bubble.insn     = NOP_INSN;
    if_bubble.valid    = 1'b0;
    if_bubble.pc       = if_id.pc;
    if_bubble.insn     = NOP_INSN;
  end

  assign stall_out = if_id.valid && id_ex.valid &&
    id_ex.is_load && id_ex.dest_reg != 5'd0 &&
    (id_ex.dest_reg == f.rs ||
     (uses_rt && id_ex.dest_reg == f.rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id       <= '0;
      if_id.pc    <= RESET_PC;
      if_id.insn  <= NOP_INSN;
      id_ex       <= '0;
      id_ex.pc    <= RESET_PC;
      id_ex.insn  <= NOP_INSN;
    end else if (flush) begin
      if_id <= if_bubble;
      id_ex <= ex_bubble;
    end else if (stall_in) begin
      if_id <= if_id;
      id_ex <= id_ex;
    end else if (stall_out) begin
      id_ex <= ex_bubble;
    end else begin
      if_id.valid <= 1'b1;
      if_id.pc    <= pc_in;
      if_id.insn  <= insn_in;
      id_ex       <= dec;
    end
  end

  assign valid_out = id_ex.valid;
  assign pc_out    = id_ex.pc;
  assign insn_out  = id_ex.insn;
  assign rs_data   = id_ex.rs_data;
  assign rt_data   = id_ex.rt_data;
  assign imm_out   = id_ex.imm;
  assign dest_reg  = id_ex.dest_reg;
  assign reg_write = id_ex.reg_write;
  assign is_load   = id_ex.is_load;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: directed plan
// followed by randomized traffic against a reference model.
module tb_decode;

  localparam logic [31:0] RPC = 32'h80020000;

  logic        clk = 1'b0;
  logic        rst, flush, stall_in, wb_en;
  logic [31:0] pc_in, insn_in, wb_data;
  logic [4:0]  wb_addr;
  logic        stall_out, valid_out, reg_write, is_load;
  logic [31:0] pc_out, insn_out, rs_data, rt_data, imm_out;
  logic [4:0]  dest_reg;

  always #5 clk = ~clk;

  decode dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .insn_in   (insn_in),
    .stall_in  (stall_in),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall_out (stall_out),
    .valid_out (valid_out),
    .pc_out    (pc_out),
    .insn_out  (insn_out),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm_out   (imm_out),
    .dest_reg  (dest_reg),
    .reg_write (reg_write),
    .is_load   (is_load)
  );

  typedef struct {
    bit          v;
    logic [31:0] pc, insn, rsd, rtd, imm;
    logic [4:0]  dst;
    bit          rw, ld, st, full;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done = 1'b0;

  logic [31:0] regs [32];
  bit          mif_v = 1'b0;
  logic [31:0] mif_pc, mif_insn;
  exp_t        mex;
  bit          consumed;
  logic [31:0] fpc;

  function automatic bit ld_op(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit rt_op(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h05,
                      6'h28, 6'h29, 6'h2b};
  endfunction

  function automatic logic [4:0] ref_dest(
    input logic [31:0] i
  );
    logic [5:0] op = i[31:26];
    if (op == 6'h00)
      return (i[5:0] == 6'h08) ? 5'd0 : i[15:11];
    if (op inside {6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f})
      return i[20:16];
    if (ld_op(op)) return i[20:16];
    if (op == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_imm(
    input logic [31:0] i
  );
    int v = i[15:0];
    if (i[31:26] inside {6'h0c, 6'h0d, 6'h0e}) return v;
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic bit hz(
    input bit iv, input logic [31:0] ii, input exp_t ex
  );
    return iv && ex.v && ex.ld && ex.dst != 0 &&
      (ex.dst == ii[25:21] ||
       (rt_op(ii[31:26]) && ex.dst == ii[20:16]));
  endfunction

  function automatic logic [31:0] rdreg(
    input logic [4:0] a, input bit we,
    input logic [4:0] wa, input logic [31:0] wd
  );
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return regs[a];
  endfunction

  task automatic step(
    input bit r, input bit f, input bit si,
    input logic [31:0] pc, input logic [31:0] insn,
    input bit we, input logic [4:0] wa,
    input logic [31:0] wd
  );
    exp_t nex, bub, e;
    bit   stall_now;
    rst = r; flush = f; stall_in = si;
    pc_in = pc; insn_in = insn;
    wb_en = we; wb_addr = wa; wb_data = wd;
    consumed = 1'b0;
    stall_now = hz(mif_v, mif_insn, mex);
    nex = '{v: mif_v, pc: mif_pc, insn: mif_insn,
            rsd: rdreg(mif_insn[25:21], we, wa, wd),
            rtd: rdreg(mif_insn[20:16], we, wa, wd),
            imm: ref_imm(mif_insn),
            dst: ref_dest(mif_insn),
            rw: mif_v && ref_dest(mif_insn) != 0,
            ld: mif_v && ld_op(mif_insn[31:26]),
            st: 1'b0, full: mif_v};
    bub = '{v: 0, pc: 0, insn: 0, rsd: 0, rtd: 0, imm: 0,
            dst: 0, rw: 0, ld: 0, st: 0, full: 0};
    if (r) begin
      mif_v = 1'b0; mif_pc = RPC; mif_insn = 0;
      mex = bub; mex.pc = RPC; mex.full = 1'b1;
      for (int k = 0; k < 32; k++) regs[k] = 0;
    end else begin
      if (f) begin
        mif_v = 1'b0; mif_insn = 0; mex = bub;
      end else if (si) begin
      end else if (stall_now) begin
        mex = bub;
      end else begin
        mex = nex;
        mif_v = 1'b1; mif_pc = pc; mif_insn = insn;
        consumed = 1'b1;
      end
      if (we && wa != 0) regs[wa] = wd;
    end
    e = mex;
    e.st = hz(mif_v, mif_insn, mex);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic feed(
    input logic [31:0] insn, input bit we = 1'b0,
    input logic [4:0] wa = 5'd0,
    input logic [31:0] wd = 32'h0
  );
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, fpc, insn, we, wa, wd);
      if (consumed) break;
    end
    fpc = fpc + 4;
  endtask

  task automatic chk(
    input string n, input logic [31:0] a,
    input logic [31:0] e
  );
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h t=%0t",
               n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] rand_insn();
    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h02, 6'h03,
      6'h04, 6'h05, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h2b,
      6'h08, 6'h3f};
    logic [5:0]  op = ops[$urandom_range(0, 19)];
    logic [4:0]  rs = 5'($urandom_range(0, 7));
    logic [4:0]  rt = 5'($urandom_range(0, 7));
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [5:0]  fn = ($urandom_range(0, 5) == 0)
                      ? 6'h08 : 6'h21;
    logic [15:0] im = 16'($urandom);
    if (op == 6'h00) return {op, rs, rt, rd, 5'd0, fn};
    return {op, rs, rt, im};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!done) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_underflow t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk("valid_out", 32'(valid_out), 32'(e.v));
          chk("insn_out", insn_out, e.insn);
          chk("reg_write", 32'(reg_write), 32'(e.rw));
          chk("is_load", 32'(is_load), 32'(e.ld));
          chk("stall_out", 32'(stall_out), 32'(e.st));
          if (e.full) begin
            chk("pc_out", pc_out, e.pc);
            chk("rs_data", rs_data, e.rsd);
            chk("rt_data", rt_data, e.rtd);
            chk("imm_out", imm_out, e.imm);
            chk("dest_reg", 32'(dest_reg), 32'(e.dst));
          end
        end
      end
    end
  end

  initial begin : stim
    bit          r, f, si, we;
    logic [31:0] ins;
    fpc = RPC;
    step(1, 0, 0, fpc, 0, 0, 0, 0);
    step(1, 0, 0, fpc, 0, 0, 0, 0);
    feed(32'h24080005);
    feed(32'h3409FFFF);
    feed(32'h2409FFFF);
    feed(32'h8C880000);
    feed(32'h01095021);
    feed(32'h0);
    feed(32'h0);
    feed(32'h00A05021);
    feed(32'h00005021, 1, 5, 32'hDEADBEEF);
    feed(32'h0, 1, 0, 32'hFFFFFFFF);
    feed(32'h0);
    feed(32'h8C880000);
    feed(32'h01095021);
    step(0, 1, 0, fpc, 32'h0, 0, 0, 0);
    fpc = 32'h80030000;
    feed(32'h24080007);
    feed(32'h0);
    feed(32'h01095021);
    step(0, 0, 1, fpc, 32'h0, 0, 0, 0);
    step(0, 0, 1, fpc, 32'h0, 1, 9, 32'h12345678);
    step(0, 0, 1, fpc, 32'h0, 0, 0, 0);
    feed(32'h0);
    feed(32'h0);
    feed(32'h24090003);
    fpc = RPC;
    step(1, 0, 0, fpc, 32'h24090003, 0, 0, 0);
    ins = rand_insn();
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 15) == 0);
      si = ($urandom_range(0, 7) == 0);
      we = $urandom_range(0, 1) == 1;
      step(r, f, si, fpc, ins, we,
           5'($urandom_range(0, 7)), $urandom);
      if (r) begin
        fpc = RPC; ins = rand_insn();
      end else if (f) begin
        fpc = $urandom & ~32'h3; ins = rand_insn();
      end else if (consumed) begin
        fpc = fpc + 4; ins = rand_insn();
      end
    end
    done = 1'b1;
    @(posedge clk); #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
